// File: rtl/rgb_rescale_if.sv
// Pixel stream bundle for rgb_rescale: source pixel with its channel-max metadata
// and the rescaled output pixel.
interface rgb_rescale_if #(
    parameter int CH_W = 8
);
    logic                src_valid;
    logic [3*CH_W-1:0]   src_data;
    logic [CH_W-1:0]     src_max;
    logic [1:0]          src_index;
    logic [CH_W-1:0]     src_enh;
    logic                src_last;
    logic                dst_valid;
    logic [3*CH_W-1:0]   dst_data;
    logic                dst_last;

    modport master (
        output src_valid, src_data, src_max, src_index, src_enh, src_last,
        input  dst_valid, dst_data, dst_last
    );

    modport slave (
        input  src_valid, src_data, src_max, src_index, src_enh, src_last,
        output dst_valid, dst_data, dst_last
    );
endinterface

// File: rtl/rgb_rescale.sv
// Rebuilds an RGB pixel from its CLAHE-enhanced max: channel = c*enh/max via a
// fully pipelined restoring divider. Optional macro RGB_RESCALE_ROUND_EN rounds half up.
module rgb_rescale #(
    parameter int CH_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rgb_rescale_if.slave  bus
);
    localparam int PIPE = CH_W + 2;

    // Index 0 is the multiply stage; index k holds k quotient bits.
    logic [CH_W-1:0] rem_reg [0:CH_W][0:2];
    logic [CH_W-1:0] quo_reg [0:CH_W][0:2];
    logic [CH_W-1:0] low_reg [0:CH_W-1][0:2];
    logic            sat_reg [0:CH_W][0:2];
    logic [CH_W-1:0] max_reg [0:CH_W];
    logic [CH_W-1:0] enh_reg [0:CH_W];
    logic [1:0]      idx_reg [0:CH_W];
    logic            zero_reg [0:CH_W];

    logic [PIPE-1:0]   valid_sr;
    logic [PIPE-1:0]   last_sr;
    logic [3*CH_W-1:0] data_reg;
    logic [CH_W-1:0]   res_c [0:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_reg[0]  <= '0;
            enh_reg[0]  <= '0;
            idx_reg[0]  <= '0;
            zero_reg[0] <= 1'b0;
        end else begin
            max_reg[0]  <= bus.src_max;
            enh_reg[0]  <= bus.src_enh;
            idx_reg[0]  <= bus.src_index;
            zero_reg[0] <= (bus.src_max == '0);
        end
    end

    genvar gi, gc;
    generate
        for (gc = 0; gc < 3; gc++) begin : g_mul
            logic [CH_W-1:0]   c_in;
            logic [2*CH_W-1:0] prod;
            assign c_in = bus.src_data[gc*CH_W +: CH_W];
            assign prod = (2*CH_W)'(c_in) * (2*CH_W)'(bus.src_enh);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_reg[0][gc] <= '0;
                    low_reg[0][gc] <= '0;
                    quo_reg[0][gc] <= '0;
                    sat_reg[0][gc] <= 1'b0;
                end else begin
                    rem_reg[0][gc] <= prod[2*CH_W-1:CH_W];
                    low_reg[0][gc] <= prod[CH_W-1:0];
                    quo_reg[0][gc] <= '0;
                    sat_reg[0][gc] <= (c_in > bus.src_max);
                end
            end
        end

        for (gi = 1; gi <= CH_W; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    max_reg[gi]  <= '0;
                    enh_reg[gi]  <= '0;
                    idx_reg[gi]  <= '0;
                    zero_reg[gi] <= 1'b0;
                end else begin
                    max_reg[gi]  <= max_reg[gi-1];
                    enh_reg[gi]  <= enh_reg[gi-1];
                    idx_reg[gi]  <= idx_reg[gi-1];
                    zero_reg[gi] <= zero_reg[gi-1];
                end
            end

            for (gc = 0; gc < 3; gc++) begin : g_ch
                logic [CH_W:0] trial;
                logic [CH_W:0] diff;
                logic          ge;
                // Bring down the next dividend bit; remainder stays below max
                // whenever c <= max, so it fits back into CH_W bits.
                assign trial = {rem_reg[gi-1][gc], low_reg[gi-1][gc][CH_W-1]};
                assign diff  = trial - {1'b0, max_reg[gi-1]};
                assign ge    = (trial >= {1'b0, max_reg[gi-1]});

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        rem_reg[gi][gc] <= '0;
                        quo_reg[gi][gc] <= '0;
                        sat_reg[gi][gc] <= 1'b0;
                    end else begin
                        rem_reg[gi][gc] <= ge ? diff[CH_W-1:0] : trial[CH_W-1:0];
                        quo_reg[gi][gc] <= {quo_reg[gi-1][gc][CH_W-2:0], ge};
                        sat_reg[gi][gc] <= sat_reg[gi-1][gc];
                    end
                end

                if (gi < CH_W) begin : g_low
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            low_reg[gi][gc] <= '0;
                        end else begin
                            low_reg[gi][gc] <= low_reg[gi-1][gc] << 1;
                        end
                    end
                end
            end
        end

        for (gc = 0; gc < 3; gc++) begin : g_out
            logic [CH_W-1:0] q_fin;
`ifdef RGB_RESCALE_ROUND_EN
            logic round_up;
            assign round_up = ({rem_reg[CH_W][gc], 1'b0} >= {1'b0, max_reg[CH_W]});
            assign q_fin    = (round_up && (quo_reg[CH_W][gc] != '1))
                              ? quo_reg[CH_W][gc] + 1'b1 : quo_reg[CH_W][gc];
`else
            assign q_fin    = quo_reg[CH_W][gc];
`endif
            always_comb begin
                res_c[gc] = q_fin;
                if (zero_reg[CH_W]) begin
                    res_c[gc] = enh_reg[CH_W];
                end else if (idx_reg[CH_W] == 2'(gc)) begin
                    res_c[gc] = enh_reg[CH_W];
                end else if (sat_reg[CH_W][gc]) begin
                    res_c[gc] = '1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            last_sr  <= '0;
            data_reg <= '0;
        end else begin
            valid_sr <= {valid_sr[PIPE-2:0], bus.src_valid};
            last_sr  <= {last_sr[PIPE-2:0], bus.src_last};
            data_reg <= {res_c[2], res_c[1], res_c[0]};
        end
    end

    assign bus.dst_valid = valid_sr[PIPE-1];
    assign bus.dst_last  = last_sr[PIPE-1];
    assign bus.dst_data  = data_reg;
endmodule

// File: tb/tb_rgb_rescale.sv
// Self-checking bench for rgb_rescale: directed and random pixels compared against
// an arithmetic model delayed by the 10-cycle pipeline latency.
module tb_rgb_rescale;
    localparam int LAT = 10;

    typedef struct {
        logic        v;
        logic        l;
        logic [23:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    exp_t exp_q[$];

    rgb_rescale_if #(.CH_W(8)) bus ();

    rgb_rescale #(.CH_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model(logic [23:0] px, int mx, int idx, int enh);
        logic [23:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            int ch, v, q, rm;
            ch = int'(px[c*8 +: 8]);
            if (mx == 0 || idx == c) begin
                v = enh;
            end else if (ch > mx) begin
                v = 255;
            end else begin
                q  = (ch * enh) / mx;
                rm = (ch * enh) % mx;
`ifdef RGB_RESCALE_ROUND_EN
                if (2 * rm >= mx && q < 255) q = q + 1;
`endif
                v = q;
            end
            res[c*8 +: 8] = v[7:0];
        end
        return res;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(logic v, logic [23:0] px, logic [7:0] mx, logic [1:0] idx,
                         logic [7:0] enh, logic l);
        bus.src_valid = v;
        bus.src_data  = px;
        bus.src_max   = mx;
        bus.src_index = idx;
        bus.src_enh   = enh;
        bus.src_last  = l;
    endtask

    task automatic idle();
        drive(1'b0, 24'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), 1'b0);
    endtask

    // One clock: record what the model expects for the inputs now on the bus,
    // then check the output that entered the pipe LAT cycles ago.
    task automatic tick();
        exp_t e;
        e.v = bus.src_valid;
        e.l = bus.src_last;
        e.d = bus.src_valid ? model(bus.src_data, int'(bus.src_max), int'(bus.src_index),
                                    int'(bus.src_enh)) : 24'h0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            chk("dst_valid", 32'(bus.dst_valid), 32'(e.v));
            chk("dst_last", 32'(bus.dst_last), 32'(e.l));
            if (e.v) begin
                chk("dst_data", 32'(bus.dst_data), 32'(e.d));
                n_out++;
                $display("out %0d: data=%06h expected=%06h last=%0b", n_out, bus.dst_data, e.d,
                         bus.dst_last);
            end
        end else begin
            chk("fill_valid", 32'(bus.dst_valid), 32'h0);
        end
    endtask

    task automatic rand_pixel(logic l);
        logic [7:0]  r, g, b, mx;
        logic [1:0]  idx;
        r  = 8'($urandom);
        g  = 8'($urandom);
        b  = 8'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            r = 8'($urandom_range(0, 3));
            g = 8'($urandom_range(0, 3));
            b = 8'($urandom_range(0, 3));
        end
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        if ($urandom_range(0, 7) == 0) idx = 2'd3;
        else if (r == mx)              idx = 2'd2;
        else if (g == mx)              idx = 2'd1;
        else                           idx = 2'd0;
        drive(1'b1, {r, g, b}, mx, idx, 8'($urandom), l);
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.dst_valid), 32'h0);
        chk("reset_data", 32'(bus.dst_data), 32'h0);
        chk("reset_last", 32'(bus.dst_last), 32'h0);
        rst_n = 1'b1;

        // Directed pixels from the plan, including black and enh=0
        drive(1'b1, {8'd200, 8'd100, 8'd50}, 8'd200, 2'd2, 8'd250, 1'b0); tick();
        drive(1'b1, 24'h000000, 8'd0, 2'd0, 8'd37, 1'b0);                  tick();
        drive(1'b1, {8'd90, 8'd90, 8'd90}, 8'd90, 2'd1, 8'd0, 1'b0);      tick();
        drive(1'b1, {8'd255, 8'd10, 8'd10}, 8'd100, 2'd3, 8'd200, 1'b0);  tick();
        drive(1'b1, {8'd255, 8'd254, 8'd1}, 8'd255, 2'd2, 8'd255, 1'b0);  tick();
        drive(1'b1, {8'd3, 8'd1, 8'd2}, 8'd3, 2'd3, 8'd255, 1'b0);        tick();

        // Gapped pattern 1,0,1,1,0
        rand_pixel(1'b0); tick();
        idle();           tick();
        rand_pixel(1'b0); tick();
        rand_pixel(1'b0); tick();
        idle();           tick();
        repeat (LAT + 2) begin idle(); tick(); end

        // Back-to-back line of 640 pixels, last flagged on the final one
        for (int i = 0; i < 640; i++) begin
            rand_pixel(i == 639);
            tick();
        end
        repeat (LAT + 2) begin idle(); tick(); end

        // Reset with 5 pixels in flight: they must never emerge
        repeat (5) begin rand_pixel(1'b1); tick(); end
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.dst_valid), 32'h0);
        chk("midrst_data", 32'(bus.dst_data), 32'h0);
        chk("midrst_last", 32'(bus.dst_last), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, {8'd120, 8'd60, 8'd30}, 8'd120, 2'd2, 8'd181, 1'b1); tick();
        repeat (LAT + 3) begin idle(); tick(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rgb_rescale.md
Name: rgb_rescale

Overview:
- Inverse of the CLAHE front-end channel-max stage: rebuilds an RGB pixel from the original pixel, its original max channel value and the CLAHE-enhanced max value.
- Each channel is scaled by enh/max so that hue and saturation are preserved.
- Sits after the CLAHE mapping/interpolation stage and drives the video output stream.
- Fully pipelined, one pixel per clock, no backpressure.

Parameters:
- CH_W, 8, bits per colour channel. Pixel width is 3*CH_W. Latency is CH_W+2 cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- src_valid  input  1  input pixel qualifier
- src_data  input  3*CH_W  original pixel {R,G,B}; R=[23:16], G=[15:8], B=[7:0]
- src_max  input  CH_W  original max of the three channels
- src_index  input  2  channel holding the max: 2=R, 1=G, 0=B, 3=none
- src_enh  input  CH_W  enhanced max value from CLAHE
- src_last  input  1  end-of-line marker, delayed alongside data
- dst_valid  output  1  output pixel qualifier
- dst_data  output  3*CH_W  rescaled pixel {R,G,B}
- dst_last  output  1  delayed src_last

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers, dst_valid, dst_data and dst_last go to 0.
- Latency: exactly CH_W+2 clocks (10 for the default) from src_* sampled to dst_*, for every input.
- Throughput is 1 pixel/clock. No stall and no ready signal.
- Data-path registers update every cycle regardless of src_valid. Valid and last travel through a (CH_W+2)-deep shift register.
- Stage 1, per channel c:
  - p = c*src_enh, 2*CH_W bits, unsigned.
  - Register the divisor src_max, src_enh and src_index.
  - Flag sat = (c > src_max).
  - Flag zero = (src_max == 0).
- Stages 2..CH_W+1: restoring division of p by max, one quotient bit per stage, MSB first.
  - Partial remainder is CH_W+1 bits.
  - Because c <= max, the quotient fits in CH_W bits.
- Stage CH_W+2 (output), per channel, in this priority order:
  1. zero: channel = enh. A black pixel becomes grey at level enh.
  2. Channel is the one named by index (index 0..2): channel = enh exactly, with no division error.
  3. sat: channel = 2^CH_W-1. This case is an illegal input; the saturation is defined behaviour.
  4. Otherwise: channel = quotient, with optional rounding (see Optional Feature).
- index=3: no channel is forced and all three channels take the division result.
- Output is always <= 2^CH_W-1. No wrap-around is permitted.
- Reset mid-stream:
  - All in-flight pixels are discarded and dst_valid stays 0 until new pixels traverse the pipeline.
  - A pixel presented on the first cycle after reset release is processed normally.
- dst_last is asserted on the same cycle as the dst_valid of the pixel that carried src_last.

Optional Feature:
- Macro: RGB_RESCALE_ROUND_EN.
- Defined: round half up. If 2*remainder >= max, the quotient is incremented, saturating at 2^CH_W-1.
- Undefined: quotient truncated (floor).
- Latency is identical in both builds. Forced and zero channels are unaffected.

Test Plan:
- Single pixel {200,100,50}, max=200, idx=2, enh=250 -> 10 cycles later dst_valid=1 and dst_data={250,125,62}, or {250,125,63} with RGB_RESCALE_ROUND_EN.
- Pixel {0,0,0}, max=0, idx=0, enh=37 -> dst_data={37,37,37}. Pixel {90,90,90}, max=90, idx=1, enh=0 -> {0,0,0}.
- Back-to-back stream of 640 random consistent pixels, src_last on the last one:
  - dst_valid high for 640 consecutive cycles starting at cycle 10.
  - Every output matches the reference model floor/round(c*enh/max).
  - dst_last high only on output 640.
- Illegal input {255,10,10}, max=100, idx=3, enh=200 -> R saturates to 255, G=B=20.
- Gapped input (src_valid 1,0,1,1,0) -> dst_valid shows the identical pattern delayed by exactly 10 cycles.
- Assert rst_n low for 1 cycle while 5 pixels are in flight -> dst_valid, dst_data and dst_last go to 0 immediately. None of the 5 pixels ever appear. A new pixel after release emerges 10 cycles later.
